q_meter: RTL

//   Ring-down Q-factor meter; the producer side of the q_measured/ready interface consumed by the bisection controller.

---
 rtl/q_meter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/q_meter.sv
// Ring-down Q-factor meter: excite, release, count oscillation periods while the envelope decays HI -> LO.
// Define Q_AVG_EN to publish the truncated mean of every four consecutive counts instead of each count.
module q_meter #(
  parameter int unsigned BUS_WIDTH   = 10,
  parameter int unsigned EXC_CYCLES  = 256,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 osc_cmp,
  input  logic                 env_hi,
  input  logic                 env_lo,
  output logic                 excite,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 timeout
);

  localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned EXC_W = (EXC_CYCLES > 1) ? $clog2(EXC_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EXCITE, S_WAIT_HI, S_COUNT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NSYNC-1:0]     osc_sync_q, osc_sync_d;
  logic [NSYNC-1:0]     hi_sync_q, hi_sync_d;
  logic [NSYNC-1:0]     lo_sync_q, lo_sync_d;
  logic                 osc_dly_q, osc_dly_d;
  logic [EXC_W-1:0]     exc_cnt_q, exc_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [BUS_WIDTH-1:0] n_cnt_q, n_cnt_d;
  logic [BUS_WIDTH-1:0] q_meas_q, q_meas_d;
  logic                 excite_q, excite_d;
  logic                 ready_q, ready_d;
  logic                 timeout_q, timeout_d;
  logic                 osc_s, hi_s, lo_s, osc_rise;

`ifdef Q_AVG_EN
  localparam int unsigned ACC_W = BUS_WIDTH + 2;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [1:0]       smp_q, smp_d;
  assign acc_sum = acc_q + ACC_W'(n_cnt_q);
`endif

  assign osc_s    = osc_sync_q[NSYNC-1];
  assign hi_s     = hi_sync_q[NSYNC-1];
  assign lo_s     = lo_sync_q[NSYNC-1];
  assign osc_rise = osc_s & ~osc_dly_q;

  // Next-state, counters and registered outputs
  always_comb begin
    osc_sync_d = {osc_sync_q[NSYNC-2:0], osc_cmp};
    hi_sync_d  = {hi_sync_q[NSYNC-2:0], env_hi};
    lo_sync_d  = {lo_sync_q[NSYNC-2:0], env_lo};
    osc_dly_d  = osc_s;
    state_d    = state_q;
    exc_cnt_d  = exc_cnt_q;
    to_cnt_d   = to_cnt_q;
    n_cnt_d    = n_cnt_q;
    q_meas_d   = q_meas_q;
    excite_d   = 1'b0;
    ready_d    = 1'b0;
    timeout_d  = 1'b0;
`ifdef Q_AVG_EN
    acc_d      = acc_q;
    smp_d      = smp_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_EXCITE;
          exc_cnt_d = '0;
          excite_d  = 1'b1;
        end
      end
      S_EXCITE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (hi_s || exc_cnt_q == EXC_W'(EXC_CYCLES - 1)) begin
          state_d  = S_WAIT_HI;
          to_cnt_d = '0;
        end else begin
          exc_cnt_d = exc_cnt_q + EXC_W'(1);
          excite_d  = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (!hi_s) begin
            n_cnt_d = '0;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          // A rise coinciding with the LO crossing still counts
          if (osc_rise && n_cnt_q != '1) n_cnt_d = n_cnt_q + BUS_WIDTH'(1);
          if (!lo_s) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef Q_AVG_EN
        if (smp_q == 2'd3) begin
          q_meas_d = BUS_WIDTH'(acc_sum >> 2);
          ready_d  = 1'b1;
          acc_d    = '0;
          smp_d    = '0;
        end else begin
          acc_d = acc_sum;
          smp_d = smp_q + 2'd1;
        end
`else
        q_meas_d = n_cnt_q;
        ready_d  = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef Q_AVG_EN
    if (state_q != S_DONE && (timeout_d || !enable)) begin
      acc_d = '0;
      smp_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      osc_sync_q <= '0;
      hi_sync_q  <= '0;
      lo_sync_q  <= '0;
      osc_dly_q  <= 1'b0;
      exc_cnt_q  <= '0;
      to_cnt_q   <= '0;
      n_cnt_q    <= '0;
      q_meas_q   <= '0;
      excite_q   <= 1'b0;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef Q_AVG_EN
      acc_q      <= '0;
      smp_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      osc_sync_q <= osc_sync_d;
      hi_sync_q  <= hi_sync_d;
      lo_sync_q  <= lo_sync_d;
      osc_dly_q  <= osc_dly_d;
      exc_cnt_q  <= exc_cnt_d;
      to_cnt_q   <= to_cnt_d;
      n_cnt_q    <= n_cnt_d;
      q_meas_q   <= q_meas_d;
      excite_q   <= excite_d;
      ready_q    <= ready_d;
      timeout_q  <= timeout_d;
`ifdef Q_AVG_EN
      acc_q      <= acc_d;
      smp_q      <= smp_d;
`endif
    end
  end

  assign excite     = excite_q;
  assign q_measured = q_meas_q;
  assign ready      = ready_q;
  assign timeout    = timeout_q;

endmodule
